// File: rtl/asym_fifo_b2w_pkg.sv
// Shared types and helpers for the byte-in / word-out asymmetric FIFO.
package asym_fifo_pkg;

  // Number of byte lanes packed into one read word.
  localparam int LANES = 2;

  // Byte lane inside a word: LANE_LO holds the first byte written.
  typedef enum logic {LANE_LO, LANE_HI} lane_e;

  // Read-side word width for a given byte width.
  function automatic int word_w(input int byte_w);
    return LANES * byte_w;
  endfunction

endpackage

// File: rtl/asym_fifo_b2w_if.sv
// Byte write / word read handshake bundle for asym_fifo_b2w.
interface asym_fifo_b2w_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int BYTE_W     = 8
);
  import asym_fifo_pkg::*;

  logic                          wr_en;
  logic [BYTE_W-1:0]             wr_data;
  logic                          full;
  logic                          rd_en;
  logic [word_w(BYTE_W)-1:0]     rd_data;
  logic                          empty;
  logic                          partial;
  logic [ADDR_WIDTH:0]           word_count;

  // Producer/consumer side (drives requests, observes status).
  modport master (
    output wr_en, wr_data, rd_en,
    input  full, rd_data, empty, partial, word_count
  );

  // FIFO side.
  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, rd_data, empty, partial, word_count
  );

endinterface

// File: rtl/asym_fifo_b2w_ctrl.sv
// Pointer and flag controller: byte-granular write pointer, word-granular
// read pointer, each carrying a wrap MSB to tell full from empty.
module asym_fifo_b2w_ctrl
  import asym_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic                  full,
  output logic                  empty,
  output logic                  partial,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  wr_we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output lane_e                 wr_lane,
  output logic [ADDR_WIDTH-1:0] rd_addr
);

  logic [ADDR_WIDTH+1:0] wr_ptr_r;
  logic [ADDR_WIDTH:0]   rd_ptr_r;
  logic [ADDR_WIDTH:0]   wr_word_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;

  // Word part of the write pointer; bit 0 of wr_ptr_r is the byte lane.
  assign wr_word_s = wr_ptr_r[ADDR_WIDTH+1:1];

  // Flags come only from registered pointers; a lone pending byte keeps empty.
  assign empty_s  = (wr_word_s == rd_ptr_r);
  assign full_s   = (wr_word_s[ADDR_WIDTH] != rd_ptr_r[ADDR_WIDTH]) &&
                    (wr_word_s[ADDR_WIDTH-1:0] == rd_ptr_r[ADDR_WIDTH-1:0]);
  assign wr_acc_s = wr_en && !full_s;
  assign rd_acc_s = rd_en && !empty_s;

  assign full       = full_s;
  assign empty      = empty_s;
  assign partial    = wr_ptr_r[0];
  assign word_count = wr_word_s - rd_ptr_r;
  assign wr_we      = wr_acc_s;
  assign wr_addr    = wr_word_s[ADDR_WIDTH-1:0];
  assign wr_lane    = lane_e'(wr_ptr_r[0]);
  assign rd_addr    = rd_ptr_r[ADDR_WIDTH-1:0];

  // Advance pointers on accepted requests; reset discards any pending byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {(ADDR_WIDTH+2){1'b0}};
      rd_ptr_r <= {(ADDR_WIDTH+1){1'b0}};
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + {{(ADDR_WIDTH+1){1'b0}}, 1'b1};
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/asym_fifo_b2w.sv
// Asymmetric FWFT FIFO: bytes in, little-endian 16-bit words out.
// Storage is split into a low-lane and a high-lane array so each byte write
// touches only its own lane.
module asym_fifo_b2w
  import asym_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int BYTE_W     = 8
) (
  input  logic           clk,
  input  logic           rst,
  asym_fifo_b2w_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [BYTE_W-1:0]     mem_lo_r [DEPTH];
  logic [BYTE_W-1:0]     mem_hi_r [DEPTH];
  logic                  wr_we_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  lane_e                 wr_lane_s;
  logic [ADDR_WIDTH-1:0] rd_addr_s;

  asym_fifo_b2w_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (bus.wr_en),
    .rd_en      (bus.rd_en),
    .full       (bus.full),
    .empty      (bus.empty),
    .partial    (bus.partial),
    .word_count (bus.word_count),
    .wr_we      (wr_we_s),
    .wr_addr    (wr_addr_s),
    .wr_lane    (wr_lane_s),
    .rd_addr    (rd_addr_s)
  );

  // Byte-lane write into the register file; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_we_s) begin
      if (wr_lane_s == LANE_LO) begin
        mem_lo_r[wr_addr_s] <= bus.wr_data;
      end else begin
        mem_hi_r[wr_addr_s] <= bus.wr_data;
      end
    end
  end

  // Fall-through head word: first byte in the low half.
  assign bus.rd_data = {mem_hi_r[rd_addr_s], mem_lo_r[rd_addr_s]};

endmodule

// File: tb/tb_asym_fifo_b2w.sv
// Self-checking bench for asym_fifo_b2w (ADDR_WIDTH=2, 4 words).
module tb_asym_fifo_b2w;

  localparam int AW = 2;
  localparam int BW = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  asym_fifo_b2w_if #(.ADDR_WIDTH(AW), .BYTE_W(BW)) bus ();

  asym_fifo_b2w #(.ADDR_WIDTH(AW), .BYTE_W(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       rd;
    logic       e_empty;
    logic       e_full;
    logic       e_partial;
    int         e_count;
  } vec_t;

  vec_t vecs[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of complete words plus one pending byte.
  logic [15:0] sb[$];
  logic [7:0]  m_pend;
  bit          m_has_pend;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic [7:0] d, input logic rd,
                     input logic e, input logic f, input logic p, input int c);
    vec_t v;
    v.wr = wr; v.data = d; v.rd = rd;
    v.e_empty = e; v.e_full = f; v.e_partial = p; v.e_count = c;
    vecs.push_back(v);
  endtask

  // Compare DUT status and head word against the model.
  task automatic chk_model(input string tag);
    chk({tag, " empty"}, int'(bus.empty), int'(sb.size() == 0));
    chk({tag, " full"}, int'(bus.full), int'(sb.size() == DEPTH));
    chk({tag, " partial"}, int'(bus.partial), int'(m_has_pend));
    chk({tag, " count"}, int'(bus.word_count), sb.size());
    if (sb.size() != 0) chk({tag, " head"}, int'(bus.rd_data), int'(sb[0]));
  endtask

  // One clock of stimulus; pops are scored against the queue before the edge.
  task automatic step(input logic wr, input logic [7:0] d, input logic rd,
                      input string tag);
    bit acc_w, acc_r;
    @(negedge clk);
    bus.wr_en = wr; bus.wr_data = d; bus.rd_en = rd;
    acc_w = wr && (sb.size() != DEPTH);
    acc_r = rd && (sb.size() != 0);
    #1;
    if (acc_r) chk({tag, " pop"}, int'(bus.rd_data), int'(sb.pop_front()));
    if (acc_w) begin
      if (m_has_pend) begin
        sb.push_back({d, m_pend});
        m_has_pend = 1'b0;
      end else begin
        m_pend = d;
        m_has_pend = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    chk_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    m_has_pend = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.rd_en = 1'b0;
    m_has_pend = 1'b0;
    m_pend = 8'h00;

    // Hand-derived expected flags for the directed table.
    add(1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    add(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    for (int k = 1; k <= 8; k++)
      add(1'b1, 8'(k), 1'b0, logic'(k < 2), logic'(k == 8), logic'(k % 2), k / 2);
    add(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 4);
    for (int k = 3; k >= 0; k--)
      add(1'b0, 8'h00, 1'b1, logic'(k == 0), 1'b0, 1'b0, k);
    for (int k = 1; k <= 8; k++)
      add(1'b1, 8'(8'hB0 + k), 1'b0, logic'(k < 2), logic'(k == 8), logic'(k % 2), k / 2);
    add(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 3);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset empty", int'(bus.empty), 1);
    chk("reset full", int'(bus.full), 0);
    chk("reset partial", int'(bus.partial), 0);
    chk("reset count", int'(bus.word_count), 0);

    foreach (vecs[i]) begin
      step(vecs[i].wr, vecs[i].data, vecs[i].rd, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d t_empty", i), int'(bus.empty), int'(vecs[i].e_empty));
      chk($sformatf("vec%0d t_full", i), int'(bus.full), int'(vecs[i].e_full));
      chk($sformatf("vec%0d t_partial", i), int'(bus.partial), int'(vecs[i].e_partial));
      chk($sformatf("vec%0d t_count", i), int'(bus.word_count), vecs[i].e_count);
      if (i == 1) chk("first word", int'(bus.rd_data), 16'h2211);
      if (i == 11) chk("full head", int'(bus.rd_data), 16'h0201);
    end

    // Drain the three words left after the simultaneous full case.
    for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b1, "drain");

    // Empty with a pending byte: the read is ignored, the write completes it.
    step(1'b1, 8'h33, 1'b0, "pend");
    step(1'b1, 8'h44, 1'b1, "pend_wr_rd");
    chk("pend word", int'(bus.rd_data), 16'h4433);
    chk("pend notempty", int'(bus.empty), 0);
    step(1'b0, 8'h00, 1'b1, "pend_pop");

    // Three full/empty rounds to exercise pointer wrap.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 8; k++) step(1'b1, 8'(8'h40 + 8 * r + k), 1'b0, $sformatf("wrap%0d_w", r));
      chk($sformatf("wrap%0d full", r), int'(bus.full), 1);
      for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b1, $sformatf("wrap%0d_r", r));
      chk($sformatf("wrap%0d empty", r), int'(bus.empty), 1);
    end

    // Mid-operation reset discards words and the pending byte.
    for (int k = 0; k < 5; k++) step(1'b1, 8'(8'hC0 + k), 1'b0, "prerst");
    do_reset();
    chk("mrst empty", int'(bus.empty), 1);
    chk("mrst partial", int'(bus.partial), 0);
    chk("mrst count", int'(bus.word_count), 0);
    chk("mrst full", int'(bus.full), 0);
    step(1'b1, 8'h5A, 1'b0, "post_rst0");
    step(1'b1, 8'hA5, 1'b0, "post_rst1");
    chk("post rst word", int'(bus.rd_data), 16'hA55A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
